// File: rtl/obstacle_scheduler_pkg.sv
// obstacle_scheduler_pkg: shared FSM states, screen constants and lane helper for the obstacle scheduler
package obstacle_pkg;
  typedef enum logic [2:0] {IDLE, UPDATE, SPAWN, CHECK, DONE} state_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int LANE_BASE = 96;
  localparam int LANE_STEP = 96;
  localparam int GAP_MIN = 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [9:0] lane_y(input logic [1:0] sel);
    return 10'(LANE_BASE + LANE_STEP * int'(sel));
  endfunction
endpackage

// File: rtl/obstacle_scheduler_if.sv
// obstacle_scheduler_if: control, pixel-position and status signals between game logic and the scheduler
interface obstacle_scheduler_if;
  logic       frame;
  logic       run;
  logic       clear;
  logic [9:0] HQ;
  logic [9:0] VQ;
  logic       AR;
  logic [9:0] player_y;
  logic       obs_pix;
  logic       busy;
  logic       collision;
  logic [7:0] score;
  logic       overrun;
  modport master (
    output frame, run, clear, HQ, VQ, AR, player_y,
    input  obs_pix, busy, collision, score, overrun
  );
  modport slave (
    input  frame, run, clear, HQ, VQ, AR, player_y,
    output obs_pix, busy, collision, score, overrun
  );
endinterface

// File: rtl/obstacle_scheduler_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable, async reset to seed
module lfsr16
  import obstacle_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  output logic [OUT_W-1:0] o_rnd
);
  logic [15:0] r_state;
  logic        w_fb;
  assign w_fb = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];
  assign o_rnd = r_state[OUT_W-1:0];
  // Shift right, feeding the tap parity into the top bit, once per enabled cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= LFSR_SEED;
    else if (i_step) r_state <= {w_fb, r_state[15:1]};
endmodule

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame obstacle table sequencer with registered pixel hit; OBS_SPEEDUP_EN adds score-driven speed-up
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter int NUM_OBS  = 4,
  parameter int SPEED    = 2,
  parameter int OBS_W    = 16,
  parameter int OBS_H    = 16,
  parameter int PLAYER_X = 64
) (
  input logic clk,
  input logic rst,
  obstacle_scheduler_if.slave bus
);
  localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_OBS - 1);
  state_t        r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [NUM_OBS-1:0] r_act;
  logic [9:0]    r_x [NUM_OBS];
  logic [9:0]    r_y [NUM_OBS];
  logic [5:0]    r_gap;
  logic [7:0]    r_score;
  logic          r_coll, r_over, r_pix;
  logic [4:0]    w_rnd;
  logic [3:0]    w_speed;
  logic          w_last, w_upd, w_retire, w_inc, w_hit, w_free, w_pix, w_step;
  logic [IW-1:0] w_free_idx;
  logic [9:0]    w_cx, w_cy;
  logic [10:0]   w_py;

  assign w_last   = r_idx == LAST;
  assign w_cx     = r_x[r_idx];
  assign w_cy     = r_y[r_idx];
  assign w_py     = 11'(bus.player_y);
  assign w_upd    = r_state == UPDATE && r_act[r_idx] && !bus.clear;
  assign w_retire = w_cx < 10'(w_speed);
  assign w_inc    = w_upd && w_retire && r_score != 8'hFF;
  assign w_step   = r_state == SPAWN && !bus.clear;
  assign w_hit    = r_act[r_idx]
                 && 11'(w_cx) < 11'(PLAYER_X + OBS_W)
                 && 11'(PLAYER_X) < 11'(w_cx) + 11'(OBS_W)
                 && 11'(w_cy) < w_py + 11'(OBS_H)
                 && w_py < 11'(w_cy) + 11'(OBS_H);

  assign bus.busy      = r_state != IDLE;
  assign bus.collision = r_coll;
  assign bus.overrun   = r_over;
  assign bus.score     = r_score;
  assign bus.obs_pix   = r_pix;

  lfsr16 #(.OUT_W(5)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_step(w_step),
    .o_rnd (w_rnd)
  );

`ifdef OBS_SPEEDUP_EN
  logic [3:0] r_speed;
  // Effective speed rises by one whenever the score rolls over a multiple of eight, up to 8.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_speed <= 4'(SPEED);
    else if (w_inc && r_score[2:0] == 3'd7 && r_speed < 4'd8) r_speed <= r_speed + 4'd1;
  assign w_speed = r_speed;
`else
  assign w_speed = 4'(SPEED);
`endif

  // Next-state: one pass of UPDATE slots, one SPAWN, one pass of CHECK slots, DONE; clear aborts.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (bus.frame && bus.run) ? UPDATE : IDLE;
      UPDATE:  w_next = w_last ? SPAWN : UPDATE;
      SPAWN:   w_next = CHECK;
      CHECK:   w_next = w_last ? DONE : CHECK;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.clear) w_next = IDLE;
  end

  // Lowest-index free slot; scanning downwards lets the lowest index overwrite the others.
  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--)
      if (!r_act[i]) begin
        w_free     = 1'b1;
        w_free_idx = IW'(i);
      end
  end

  // Any active obstacle box covering the current pixel.
  always_comb begin
    w_pix = 1'b0;
    for (int i = 0; i < NUM_OBS; i++)
      w_pix = w_pix | (r_act[i]
            && bus.HQ >= r_x[i] && 11'(bus.HQ) < 11'(r_x[i]) + 11'(OBS_W)
            && bus.VQ >= r_y[i] && 11'(bus.VQ) < 11'(r_y[i]) + 11'(OBS_H));
  end

  // State register and slot index; the index restarts at 0 for each slot pass.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= ((r_state == UPDATE || r_state == CHECK) && !w_last && !bus.clear) ? r_idx + IW'(1) : '0;
    end

  // Obstacle table, score and spawn gap; clear takes priority over sequencer writes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_act   <= '0;
      r_score <= '0;
      r_gap   <= 6'(GAP_MIN);
      for (int i = 0; i < NUM_OBS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else if (bus.clear) begin
      r_act   <= '0;
      r_score <= '0;
    end else if (w_upd) begin
      if (w_retire) r_act[r_idx] <= 1'b0;
      else r_x[r_idx] <= w_cx - 10'(w_speed);
      if (w_inc) r_score <= r_score + 8'd1;
    end else if (r_state == SPAWN) begin
      if (r_gap <= 6'd1) begin
        if (w_free) begin
          r_act[w_free_idx] <= 1'b1;
          r_x[w_free_idx]   <= 10'(H_ACTIVE);
          r_y[w_free_idx]   <= lane_y(w_rnd[1:0]);
          r_gap             <= 6'(GAP_MIN) + 6'(w_rnd);
        end else r_gap <= '0;
      end else r_gap <= r_gap - 6'd1;
    end

  // Sticky collision/overrun flags and the registered pixel hit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_coll <= 1'b0;
      r_over <= 1'b0;
      r_pix  <= 1'b0;
    end else begin
      r_coll <= !bus.clear && (r_coll || (r_state == CHECK && w_hit));
      r_over <= r_over || (bus.frame && r_state != IDLE);
      r_pix  <= bus.AR && w_pix;
    end
endmodule
